// File: rtl/ldlt_scheduler.sv
// Loop-nest sequencer for the LDLT datapath: issues MAC/DIV/ROW ops with RAW hazard and credit control.
// Optional stall counter output o_stall_cnt is enabled by defining LDLT_SCHED_PERF_EN.
module ldlt_scheduler #(
  parameter int NODE_NUM = 1,
  parameter int IDX_W    = 10,
  parameter int MAX_OUT  = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_abort,
  output logic             o_op_valid,
  input  logic             i_op_ready,
  output logic [1:0]       o_op_code,
  output logic [IDX_W-1:0] o_idx_i,
  output logic [IDX_W-1:0] o_idx_j,
  output logic [IDX_W-1:0] o_idx_k,
  input  logic             i_retire,
  output logic             o_busy,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_op_cnt
`ifdef LDLT_SCHED_PERF_EN
  ,
  output logic [CNT_W-1:0] o_stall_cnt
`endif
);

  localparam int DIM   = 6 * NODE_NUM;
  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam logic [1:0] OP_MAC = 2'd0;
  localparam logic [1:0] OP_DIV = 2'd1;
  localparam logic [1:0] OP_ROW = 2'd2;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t           state_q;
  logic [IDX_W-1:0] rowIdx_q, colIdx_q, innerIdx_q;
  logic [OUT_W-1:0] outCnt_q, outCnt_d;
  logic [CNT_W-1:0] opCnt_q;
  logic [1:0]       curCode;
  logic             stall, issue, retireEff, lastOp;

  // The op kind falls out of the indices: k reaching j closes the MAC run, j reaching i closes the row.
  always_comb begin
    curCode = OP_MAC;
    if (colIdx_q == rowIdx_q) begin
      curCode = OP_ROW;
    end else if (innerIdx_q == colIdx_q) begin
      curCode = OP_DIV;
    end
  end

  assign stall     = (outCnt_q == OUT_W'(MAX_OUT)) || ((curCode != OP_MAC) && (outCnt_q != '0));
  assign o_op_valid = (state_q == ISSUE) && !stall && !i_abort;
  assign issue     = o_op_valid && i_op_ready;
  assign retireEff = i_retire && (outCnt_q != '0);
  assign lastOp    = (curCode == OP_ROW) && (rowIdx_q == IDX_W'(DIM - 1));

  always_comb begin
    outCnt_d = outCnt_q;
    if (issue && !retireEff) begin
      outCnt_d = outCnt_q + OUT_W'(1);
    end else if (!issue && retireEff) begin
      outCnt_d = outCnt_q - OUT_W'(1);
    end
  end

  assign o_op_code = (state_q == ISSUE) ? curCode : 2'd0;
  assign o_idx_i   = rowIdx_q;
  assign o_idx_j   = colIdx_q;
  assign o_idx_k   = (curCode == OP_MAC) ? innerIdx_q : '0;
  assign o_busy    = (state_q != IDLE);
  assign o_valid   = (state_q == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rowIdx_q   <= '0;
      colIdx_q   <= '0;
      innerIdx_q <= '0;
      outCnt_q   <= '0;
      opCnt_q    <= '0;
    end else begin
      outCnt_q <= outCnt_d;
      if (issue && (opCnt_q != '1)) begin
        opCnt_q <= opCnt_q + CNT_W'(1);
      end
      if (i_abort && (state_q != IDLE)) begin
        state_q  <= IDLE;
        outCnt_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (i_start) begin
              state_q    <= ISSUE;
              opCnt_q    <= '0;
              rowIdx_q   <= '0;
              colIdx_q   <= '0;
              innerIdx_q <= '0;
            end
          end
          ISSUE: begin
            if (issue) begin
              case (curCode)
                OP_MAC: innerIdx_q <= innerIdx_q + IDX_W'(1);
                OP_DIV: begin
                  colIdx_q   <= colIdx_q + IDX_W'(1);
                  innerIdx_q <= '0;
                end
                default: begin
                  if (lastOp) begin
                    state_q <= DRAIN;
                  end else begin
                    rowIdx_q   <= rowIdx_q + IDX_W'(1);
                    colIdx_q   <= '0;
                    innerIdx_q <= '0;
                  end
                end
              endcase
            end
          end
          DRAIN: begin
            if (outCnt_q == '0) begin
              state_q <= DONE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign o_op_cnt = opCnt_q;

`ifdef LDLT_SCHED_PERF_EN
  logic [CNT_W-1:0] stallCnt_q;

  // Any ISSUE cycle without a completed handshake is counted as a stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCnt_q <= '0;
    end else if ((state_q == IDLE) && i_start) begin
      stallCnt_q <= '0;
    end else if ((state_q == ISSUE) && !issue && (stallCnt_q != '1)) begin
      stallCnt_q <= stallCnt_q + CNT_W'(1);
    end
  end

  assign o_stall_cnt = stallCnt_q;
`endif

endmodule

// File: tb/tb_ldlt_scheduler.sv
// Self-checking bench for ldlt_scheduler: queue-based reference of the loop nest plus a credit model.
// Covers LDLT_SCHED_PERF_EN when that macro is defined for both files.
module tb_ldlt_scheduler;

  localparam int NODE_NUM = 1;
  localparam int IDX_W    = 10;
  localparam int MAX_OUT  = 4;
  localparam int CNT_W    = 16;
  localparam int DIM      = 6 * NODE_NUM;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_start, i_abort, i_op_ready, i_retire;
  logic             o_op_valid, o_busy, o_valid;
  logic [1:0]       o_op_code;
  logic [IDX_W-1:0] o_idx_i, o_idx_j, o_idx_k;
  logic [CNT_W-1:0] o_op_cnt;
`ifdef LDLT_SCHED_PERF_EN
  logic [CNT_W-1:0] o_stall_cnt;
`endif

  typedef struct {
    int code;
    int i;
    int j;
    int k;
  } op_t;

  op_t expQ[$];
  int  dueQ[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  totalOps;

  ldlt_scheduler #(
    .NODE_NUM(NODE_NUM), .IDX_W(IDX_W), .MAX_OUT(MAX_OUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
    .o_op_valid(o_op_valid), .i_op_ready(i_op_ready), .o_op_code(o_op_code),
    .o_idx_i(o_idx_i), .o_idx_j(o_idx_j), .o_idx_k(o_idx_k),
    .i_retire(i_retire), .o_busy(o_busy), .o_valid(o_valid), .o_op_cnt(o_op_cnt)
`ifdef LDLT_SCHED_PERF_EN
    , .o_stall_cnt(o_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected issue order built straight from the i/j/k loop nest.
  task automatic buildModel();
    expQ.delete();
    for (int i = 0; i < DIM; i++) begin
      for (int j = 0; j < i; j++) begin
        for (int k = 0; k < j; k++) expQ.push_back('{0, i, j, k});
        expQ.push_back('{1, i, j, 0});
      end
      expQ.push_back('{2, i, i, 0});
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_op_valid"}, 32'(o_op_valid), 32'd0);
    checkOutput({tag, "_busy"}, 32'(o_busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(o_valid), 32'd0);
  endtask

  // readyMode: 0 always ready, 1 random ready plus stray starts, 2 ready on alternate ISSUE cycles.
  task automatic applyStimulus(input int retMin, input int retMax, input int readyMode,
                               input int abortAfter, input bit holdMac, input bit resetInDrain);
    int  modelOut, issued, ph, nextPh, cyc, holdCnt, rdyToggle, expStall;
    bit  rdy, ret, abt, expValid, iss, aborted, wasReset;
    buildModel();
    dueQ.delete();
    modelOut = 0; issued = 0; cyc = 0; holdCnt = 0; rdyToggle = 0; expStall = 0;
    aborted = 0; wasReset = 0;
    i_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_start = 1'b0;
    ph = 1;
    while (ph != 0) begin
      if (cyc >= 3000) begin
        checkOutput("timeout", 32'(ph), 32'd0);
        break;
      end
      if (resetInDrain && ph == 2) begin
        rst = 1'b1;
        #1;
        checkIdle("rst_drain");
        checkOutput("rst_op_code", 32'(o_op_code), 32'd0);
        checkOutput("rst_idx_i", 32'(o_idx_i), 32'd0);
        checkOutput("rst_idx_j", 32'(o_idx_j), 32'd0);
        checkOutput("rst_idx_k", 32'(o_idx_k), 32'd0);
        checkOutput("rst_op_cnt", 32'(o_op_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        i_retire = 1'b1;
        repeat (3) @(negedge clk);
        i_retire = 1'b0;
        wasReset = 1;
        break;
      end
      abt = (abortAfter >= 0) && (ph == 1) && (issued == abortAfter);
      expValid = (ph == 1) && !abt && (modelOut < MAX_OUT) &&
                 (expQ[0].code == 0 || modelOut == 0);
      rdy = 1'b1;
      if (readyMode == 1) rdy = ($urandom_range(0, 3) != 0);
      else if (readyMode == 2 && ph == 1) begin
        rdy = (rdyToggle % 2 == 0);
        rdyToggle++;
      end
      if (holdMac && expValid && holdCnt < 5 && expQ[0].code == 0 &&
          expQ[0].i == 3 && expQ[0].j == 2 && expQ[0].k == 1) begin
        rdy = 1'b0;
        holdCnt++;
      end
      ret = 1'b0;
      if (dueQ.size() > 0 && dueQ[0] <= cyc && modelOut > 0) begin
        ret = 1'b1;
        void'(dueQ.pop_front());
      end
      i_op_ready = rdy;
      i_retire   = ret;
      i_abort    = abt;
      i_start    = (readyMode == 1) ? ($urandom_range(0, 7) == 0) : 1'b0;
      #1;
      checkOutput("op_valid", 32'(o_op_valid), 32'(expValid));
      checkOutput("busy", 32'(o_busy), 32'd1);
      checkOutput("done", 32'(o_valid), 32'(ph == 3));
      checkOutput("op_cnt", 32'(o_op_cnt), 32'(issued));
      if (expValid) begin
        checkOutput("op_code", 32'(o_op_code), 32'(expQ[0].code));
        checkOutput("idx_i", 32'(o_idx_i), 32'(expQ[0].i));
        checkOutput("idx_j", 32'(o_idx_j), 32'(expQ[0].j));
        checkOutput("idx_k", 32'(o_idx_k), 32'(expQ[0].k));
      end
      iss = expValid && rdy;
      if (ph == 1 && !iss) expStall++;
      nextPh = ph;
      if (abt) begin
        nextPh = 0;
        aborted = 1;
      end else if (ph == 1) begin
        if (iss && expQ.size() == 1) nextPh = 2;
      end else if (ph == 2) begin
        if (modelOut == 0) nextPh = 3;
      end else begin
        nextPh = 0;
      end
      if (iss) begin
        void'(expQ.pop_front());
        issued++;
        dueQ.push_back(cyc + $urandom_range(retMin, retMax));
      end
      if (ret) modelOut--;
      if (iss) modelOut++;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      ph = nextPh;
    end
    i_abort = 1'b0; i_retire = 1'b0; i_op_ready = 1'b1; i_start = 1'b0;
    #1;
    checkIdle(wasReset ? "after_reset" : (aborted ? "after_abort" : "after_done"));
    if (!wasReset) checkOutput("final_op_cnt", 32'(o_op_cnt), 32'(aborted ? issued : totalOps));
`ifdef LDLT_SCHED_PERF_EN
    if (!wasReset) checkOutput("stall_cnt", 32'(o_stall_cnt), 32'(expStall));
`endif
    @(negedge clk);
  endtask

  initial begin
    totalOps = DIM;
    for (int i = 0; i < DIM; i++) totalOps += i * (i + 1) / 2;
    rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_op_ready = 1'b1; i_retire = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkIdle("reset");
    checkOutput("reset_op_code", 32'(o_op_code), 32'd0);
    checkOutput("reset_idx_i", 32'(o_idx_i), 32'd0);
    checkOutput("reset_idx_k", 32'(o_idx_k), 32'd0);
    checkOutput("reset_op_cnt", 32'(o_op_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] nominal run, ready high, 1-cycle retire");
    applyStimulus(1, 1, 0, -1, 1'b0, 1'b0);
    $display("[TB] ready held low on MAC(3,2,1)");
    applyStimulus(1, 1, 0, -1, 1'b1, 1'b0);
    $display("[TB] 6-cycle retire latency, credit limit");
    applyStimulus(6, 6, 0, -1, 1'b0, 1'b0);
    $display("[TB] abort after 20 ops, then fresh start");
    applyStimulus(1, 3, 0, 20, 1'b0, 1'b0);
    applyStimulus(1, 1, 0, -1, 1'b0, 1'b0);
    $display("[TB] randomized ready and retire latency");
    for (int r = 0; r < 4; r++) applyStimulus(1, 8, 1, -1, 1'b0, 1'b0);
    $display("[TB] reset during drain, spurious retires, then rerun");
    applyStimulus(6, 6, 0, -1, 1'b0, 1'b1);
    applyStimulus(1, 1, 0, -1, 1'b0, 1'b0);
    $display("[TB] ready low on alternate issue cycles");
    applyStimulus(1, 1, 2, -1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ldlt_scheduler.md
Name: ldlt_scheduler

Overview:
- Sequencing controller for the LDLT factorisation datapath.
- Walks the i/j/k loop nest of the in-place LDLT algorithm and issues one operation per handshake to a shared, pipelined MAC/divide unit.
- Tracks in-flight operations, enforces read-after-write hazards on divide steps, and signals completion once every issued operation has retired.

Parameters:
NODE_NUM, 1, node count; matrix dimension DIM = 6*NODE_NUM
IDX_W, 10, width of loop index outputs
MAX_OUT, 4, maximum operations in flight in the datapath (1..15)
CNT_W, 16, width of issued-operation counter

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
i_start  input  1  start pulse; honoured only in IDLE
i_abort  input  1  abandon factorisation; return to IDLE next cycle
o_op_valid  output  1  operation presented to datapath
i_op_ready  input  1  datapath accepts operation (issue = valid & ready)
o_op_code  output  2  0=MAC, 1=DIV, 2=ROW, 3 unused
o_idx_i  output  IDX_W  row index i
o_idx_j  output  IDX_W  column index j
o_idx_k  output  IDX_W  inner index k (0 unless MAC)
i_retire  input  1  one-cycle pulse per completed datapath operation
o_busy  output  1  high outside IDLE
o_valid  output  1  one-cycle done pulse
o_op_cnt  output  CNT_W  operations issued since last start

Behaviour:
- Reset: state IDLE; all outputs 0; i=j=k=0; outstanding=0; o_op_cnt=0.
- States: IDLE -> ISSUE on i_start (o_op_cnt cleared, indices 0). ISSUE -> DRAIN after the last op (ROW, i=DIM-1) issues. DRAIN -> DONE when outstanding==0. DONE -> IDLE unconditionally; o_valid=1 during DONE only.
- Operation order, with the loop nest advanced only on issue:
  - for i in 0..DIM-1, for j in 0..i-1, for k in 0..j-1: MAC(i,j,k).
  - After the k loop, DIV(i,j).
  - After the j loop, ROW(i,i).
  - MAC: A[i][j] -= L[i][k]*D[k]*L[j][k].
  - DIV: L[i][j] = A[i][j]/D[j], and D[i] -= A[i][j]^2/D[j].
  - ROW: end-of-row marker, no arithmetic.
- Total ops = sum_{i}(i(i+1)/2) + DIM; for DIM=6 this is 41.
- o_op_valid is high in ISSUE unless stalled. Stall when:
  - outstanding == MAX_OUT, or
  - current op is DIV or ROW and outstanding != 0 (hazard: DIV/ROW wait for all prior MACs to retire).
- Operation fields stay stable while o_op_valid=1 and i_op_ready=0.
- Outstanding counter: +1 on issue, -1 on i_retire; both in the same cycle leave it unchanged.
  - i_retire with outstanding==0 is ignored (no underflow).
  - Width is ceil(log2(MAX_OUT+1)).
- o_op_cnt increments on every issue and saturates at all-ones.
- i_abort (any non-IDLE state) -> IDLE next cycle. o_op_valid drops immediately (combinational gate), outstanding is cleared, and no o_valid pulse is produced.
- i_start while not IDLE is ignored.
- DIM=1: the only op is ROW(0,0).
- Reset mid-operation behaves exactly as the reset values above.
- Latency: first op is valid the cycle after i_start. With ready always high and 1-cycle retire, DIM=6 completes in at most 41 + hazard stalls + 2 cycles.

Optional Feature:
LDLT_SCHED_PERF_EN:
- Defined: adds output o_stall_cnt [CNT_W-1:0], cleared on start. It increments on every ISSUE-state cycle where o_op_valid=0 or i_op_ready=0, and saturates.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- DIM=6, ready=1, retire 1 cycle after each issue, start pulse:
  - Issued sequence begins ROW(0,0), DIV(1,0), ROW(1,1), DIV(2,0), MAC(2,1,0), DIV(2,1), ROW(2,2).
  - Exactly 41 ops issued; o_op_cnt=41; single o_valid pulse; o_busy then drops.
- Hold i_op_ready=0 for 5 cycles on MAC(3,2,1) -> o_op_valid stays 1 and indices stay (3,2,1) throughout; no count change.
- Hazard: delay retires by 6 cycles -> no DIV issues while outstanding>0; with MAX_OUT=4, o_op_valid stays low while outstanding==4.
- Assert i_abort mid-ISSUE after 20 ops -> IDLE next cycle, o_op_valid=0, no o_valid pulse; a fresh start then reissues 41 ops from ROW(0,0).
- Assert rst in DRAIN -> all outputs 0 immediately; spurious i_retire afterwards leaves outstanding at 0.
- With LDLT_SCHED_PERF_EN defined: ready low every other issue cycle, no hazards -> o_stall_cnt equals the number of not-ready ISSUE cycles.
